// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: fetches one instruction at a time over a req/ack imem port, then selects PC+4 or the target on retirement.
// Latency: ack in cycle N -> instr_valid in N+1 (min 2 cycles/instr). Backpressure: stall blocks retirement; imem_req held until ack or timeout.
// Optional MISALIGN_TRAP_EN: a misaligned taken target redirects to TRAP_PC with a 1-cycle trap pulse.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic [31:0] pc_target,
  input  logic        pc_src,
  input  logic        exec_done,
  input  logic        stall,
  output logic        fetch_err,
  output logic        trap
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n;
  logic [7:0]  cnt, cnt_n;
`ifdef MISALIGN_TRAP_EN
  logic        trap_q, trap_n;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    cnt_n   = cnt;
`ifdef MISALIGN_TRAP_EN
    trap_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        state_n = FETCH;
        cnt_n   = 8'd0;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          cnt_n   = 8'd0;
          state_n = EXEC;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = 8'd0;
          state_n = ERROR;
        end else begin
          cnt_n   = cnt + 8'd1;
        end
      end
      EXEC: begin
        if (exec_done && !stall) begin
          state_n = FETCH;
          if (!pc_src) begin
            pc_n = pc + 32'd4;
          end else begin
`ifdef MISALIGN_TRAP_EN
            if (pc_target[1:0] != 2'b00) begin
              pc_n   = TRAP_PC;
              trap_n = 1'b1;
            end else begin
              pc_n   = pc_target;
            end
`else
            // Low bits are forced to zero so a misaligned target still fetches a word.
            pc_n = pc_target & 32'hFFFF_FFFC;
`endif
          end
        end
      end
      default: begin
        state_n = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      instr  <= 32'd0;
      cnt    <= 8'd0;
`ifdef MISALIGN_TRAP_EN
      trap_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      instr  <= instr_n;
      cnt    <= cnt_n;
`ifdef MISALIGN_TRAP_EN
      trap_q <= trap_n;
`endif
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign fetch_err   = (state == ERROR);
`ifdef MISALIGN_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: scoreboard of expected fetch addresses and instructions, one task per scenario.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_target;
  logic        pc_src;
  logic        exec_done;
  logic        stall;
  logic        fetch_err;
  logic        trap;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] mpc;

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .pc_target(pc_target), .pc_src(pc_src),
    .exec_done(exec_done), .stall(stall), .fetch_err(fetch_err), .trap(trap)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; pc_target = 32'd0;
    pc_src = 1'b0; exec_done = 1'b0; stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    addr_q.delete(); instr_q.delete();
    addr_q.push_back(RESET_PC);
    mpc = RESET_PC;
  endtask

  task automatic fetch_one(input logic [31:0] data, input int lat);
    logic [31:0] exp;
    int w = 0;
    while (!imem_req && w < 50) begin tick(); w++; end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_fail++; $display("FAIL fetch_wait: imem_req=%b required 1 within 50 cycles", imem_req);
      return;
    end
    repeat (lat) tick();
    n_cmp++;
    exp = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    if (imem_addr !== exp || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL fetch_addr: got %h req=%b required %h", imem_addr, imem_req, exp);
    end
    imem_ack = 1'b1; imem_rdata = data; instr_q.push_back(data);
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    n_cmp++;
    exp = (instr_q.size() != 0) ? instr_q.pop_front() : 32'hDEAD_BEEF;
    if (instr_valid !== 1'b1 || instr !== exp || imem_req !== 1'b0 || pc !== mpc) begin
      n_fail++;
      $display("FAIL exec_present: valid=%b instr=%h pc=%h required valid=1 instr=%h pc=%h",
               instr_valid, instr, pc, exp, mpc);
    end
  endtask

  task automatic retire(input logic src, input logic [31:0] tgt);
    logic [31:0] nxt;
    if (!src) nxt = mpc + 32'd4;
`ifdef MISALIGN_TRAP_EN
    else if (tgt[1:0] != 2'b00) nxt = TRAP_PC;
    else nxt = tgt;
`else
    else nxt = {tgt[31:2], 2'b00};
`endif
    exec_done = 1'b1; pc_src = src; pc_target = tgt;
    tick();
    exec_done = 1'b0; pc_src = $urandom; pc_target = $urandom;
    addr_q.push_back(nxt);
    mpc = nxt;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; pc_target = 32'd0;
    pc_src = 1'b0; exec_done = 1'b0; stall = 1'b0;
    tick(); tick();
    n_cmp++;
    if (pc !== RESET_PC || imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 ||
        instr !== 32'd0 || fetch_err !== 1'b0 || trap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h req=%b addr=%h valid=%b instr=%h err=%b trap=%b required pc=%h, all else 0",
               pc, imem_req, imem_addr, instr_valid, instr, fetch_err, trap, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    fetch_one(32'h0050_0093, 0);
    retire(1'b0, 32'h0);
    fetch_one(32'h0000_0013, 0);
    retire(1'b0, 32'h0);
    fetch_one(32'h1234_5678, 1);
    retire(1'b1, 32'h0000_0040);
    fetch_one(32'hCAFE_0001, 0);
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc, hold_instr;
    retire(1'b0, 32'h0);
    fetch_one(32'hA5A5_0001, 2);
    hold_pc = mpc; hold_instr = 32'hA5A5_0001;
    exec_done = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (instr_valid !== 1'b1 || pc !== hold_pc || instr !== hold_instr || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b required 1 %h %h 0",
                 i, instr_valid, pc, instr, imem_req, hold_pc, hold_instr);
      end
    end
    stall = 1'b0;
    retire(1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== hold_pc + 32'd4) begin
      n_fail++; $display("FAIL stall_release: req=%b addr=%h required 1 %h", imem_req, imem_addr, hold_pc + 32'd4);
    end
    fetch_one(32'hA5A5_0002, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      retire(1'b0, 32'h0);
      fetch_one($urandom, $urandom_range(0, 5));
    end
  endtask

  task automatic test_timeout();
    int w = 0;
    do_reset();
    while (!imem_req && w < 10) begin tick(); w++; end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait[%0d]: req=%b err=%b required 1 0", i, imem_req, fetch_err);
      end
      tick();
    end
    n_cmp++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err: err=%b req=%b valid=%b required 1 0 0", fetch_err, imem_req, instr_valid);
    end
    imem_ack = 1'b1; exec_done = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0; exec_done = 1'b0;
    n_cmp++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: err=%b req=%b valid=%b required 1 0 0", fetch_err, imem_req, instr_valid);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if (fetch_err !== 1'b0 || pc !== RESET_PC) begin
      n_fail++; $display("FAIL timeout_clear: err=%b pc=%h required 0 %h", fetch_err, pc, RESET_PC);
    end
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    fetch_one(32'h0000_0001, 0);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch_one(32'h0000_0002, 0);
    retire(1'b0, 32'h0);
    n_cmp++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL pc_wrap: addr=%h req=%b required 00000000 1", imem_addr, imem_req);
    end
    fetch_one(32'h0000_0003, 0);
    retire(1'b0, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; reset = 1'b1;
    tick();
    imem_ack = 1'b0; reset = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || pc !== RESET_PC || instr !== 32'd0) begin
      n_fail++; $display("FAIL reset_abort: valid=%b pc=%h instr=%h required 0 %h 0", instr_valid, pc, instr, RESET_PC);
    end
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort_late: valid=%b required 0", instr_valid);
    end
    addr_q.delete(); instr_q.delete();
    addr_q.push_back(RESET_PC); mpc = RESET_PC;
    fetch_one(32'h0000_0004, 0);
  endtask

  task automatic test_misalign();
    retire(1'b1, 32'h0000_0042);
    n_cmp++;
`ifdef MISALIGN_TRAP_EN
    if (trap !== 1'b1 || pc !== 32'h0000_0100) begin
      n_fail++; $display("FAIL misalign_redirect: trap=%b pc=%h required 1 00000100", trap, pc);
    end
`else
    if (trap !== 1'b0 || pc !== 32'h0000_0040) begin
      n_fail++; $display("FAIL misalign_redirect: trap=%b pc=%h required 0 00000040", trap, pc);
    end
`endif
    tick();
    n_cmp++;
    if (trap !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: trap=%b required 0", trap);
    end
    fetch_one(32'h0000_0005, 0);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_wrap_and_abort();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
